// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I-cache / D-cache memory arbiter.
// Holds the state encodings, client IDs and the default memory latency.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_BUSY  = 3'd1,
        ST_D_BUSY  = 3'd2,
        ST_I_DRAIN = 3'd3,
        ST_D_DRAIN = 3'd4
    } arb_state_e;

    localparam logic CLIENT_I = 1'b0;
    localparam logic CLIENT_D = 1'b1;

    localparam int MEM_LATENCY_DEFAULT = 4;

    // Owner of the reads still in flight: the BUSY/DRAIN client, else the last BUSY owner.
    function automatic logic state_owner(input arb_state_e st, input logic last_owner);
        logic owner;
        case (st)
            ST_I_BUSY, ST_I_DRAIN: owner = CLIENT_I;
            ST_D_BUSY, ST_D_DRAIN: owner = CLIENT_D;
            default:               owner = last_owner;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/mem_arb_inflight_ctr.sv
// Saturating up/down counter of reads outstanding in the pipelined memory.
// zero_next reports whether the count will be zero after this clock edge.
module mem_arb_inflight_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_next
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: simultaneous inc and dec cancel; both ends saturate.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != MAX_V) begin
                count_d = count_q + W'(1);
            end else begin
                count_d = count_q;
            end
        end else if (dec && !inc) begin
            if (count_q != {W{1'b0}}) begin
                count_d = count_q - W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign zero_next = (count_d == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined data memory between the I-cache and D-cache fill paths,
// keeping ownership fixed while reads are in flight and routing read-valid to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_MemRead,
    input  logic [15:0] icache_mem_addr,
    input  logic        dcache_MemRead,
    input  logic        dcache_MemWrite,
    input  logic [15:0] dcache_mem_addr,
    input  logic [15:0] dcache_mem_write_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        icache_grant,
    output logic        dcache_grant,
    output logic        icache_MemDataValid,
    output logic        dcache_MemDataValid,
    output logic [15:0] arb_read_data
);

    arb_state_e       state_d, state_q;
    logic             last_owner_d, last_owner_q;
    logic             grant_i_s, grant_d_s;
    logic             issue_s;
    logic             zero_next_s;
    logic             data_ok_s;
    logic             owner_s;
    logic [CNT_W-1:0] inflight_s;

    // Arbitration: grants are combinational from state and requests.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (rst) begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // On a tie the client that did not own the memory last wins.
                    if ((dcache_MemRead || dcache_MemWrite) &&
                        (!icache_MemRead || (last_owner_q == CLIENT_I))) begin
                        grant_d_s = 1'b1;
                    end else if (icache_MemRead) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b0;
                    end
                end
                ST_I_BUSY: grant_i_s = icache_MemRead;
                ST_D_BUSY: grant_d_s = dcache_MemRead;
                default:   grant_i_s = 1'b0;
            endcase
        end
    end

    // Next state and last-owner update.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s && dcache_MemRead) begin
                    state_d = ST_D_BUSY;
                end else if (grant_d_s) begin
                    last_owner_d = CLIENT_D;
                end else if (grant_i_s) begin
                    state_d = ST_I_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                if (!icache_MemRead) begin
                    last_owner_d = CLIENT_I;
                    state_d      = zero_next_s ? ST_IDLE : ST_I_DRAIN;
                end else begin
                    state_d = ST_I_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (!dcache_MemRead) begin
                    last_owner_d = CLIENT_D;
                    state_d      = zero_next_s ? ST_IDLE : ST_D_DRAIN;
                end else begin
                    state_d = ST_D_BUSY;
                end
            end
            ST_I_DRAIN, ST_D_DRAIN: begin
                if (zero_next_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and last-owner registers; last owner resets to I so D wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= CLIENT_I;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Memory command mux: the granted client's command, or all zero.
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        if (grant_d_s) begin
            mem_enable  = 1'b1;
            mem_wr      = ~dcache_MemRead;
            mem_addr    = dcache_mem_addr;
            mem_data_in = dcache_mem_write_data;
        end else if (grant_i_s) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b0;
            mem_addr    = icache_mem_addr;
            mem_data_in = 16'h0000;
        end else begin
            mem_enable  = 1'b0;
        end
    end

    assign issue_s = mem_enable & ~mem_wr;

    mem_arb_inflight_ctr #(
        .MAX (MEM_LATENCY),
        .W   (CNT_W)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_s),
        .dec       (mem_data_valid),
        .count     (inflight_s),
        .zero_next (zero_next_s)
    );

    // Valid with nothing outstanding is spurious and reaches neither cache.
    assign data_ok_s           = ~rst & mem_data_valid & (inflight_s != {CNT_W{1'b0}});
    assign owner_s             = state_owner(state_q, last_owner_q);
    assign icache_grant        = grant_i_s;
    assign dcache_grant        = grant_d_s;
    assign icache_MemDataValid = data_ok_s & (owner_s == CLIENT_I);
    assign dcache_MemDataValid = data_ok_s & (owner_s == CLIENT_D);
    assign arb_read_data       = rst ? 16'h0000 : mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scripted and random cache clients, a latency-4
// memory stub, and a reference model that tracks outstanding reads as a queue of owners.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_MemRead, dcache_MemRead, dcache_MemWrite;
    logic [15:0] icache_mem_addr, dcache_mem_addr, dcache_mem_write_data;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        icache_grant, dcache_grant;
    logic        icache_MemDataValid, dcache_MemDataValid;
    logic [15:0] arb_read_data;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(LAT), .CNT_W(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .icache_MemRead        (icache_MemRead),
        .icache_mem_addr       (icache_mem_addr),
        .dcache_MemRead        (dcache_MemRead),
        .dcache_MemWrite       (dcache_MemWrite),
        .dcache_mem_addr       (dcache_mem_addr),
        .dcache_mem_write_data (dcache_mem_write_data),
        .mem_data_out          (mem_data_out),
        .mem_data_valid        (mem_data_valid),
        .mem_enable            (mem_enable),
        .mem_wr                (mem_wr),
        .mem_addr              (mem_addr),
        .mem_data_in           (mem_data_in),
        .icache_grant          (icache_grant),
        .dcache_grant          (dcache_grant),
        .icache_MemDataValid   (icache_MemDataValid),
        .dcache_MemDataValid   (dcache_MemDataValid),
        .arb_read_data         (arb_read_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          n;
        logic [15:0] base;
        logic        wr;
        logic [15:0] wdata;
    } job_t;

    job_t        i_jobs[$];
    job_t        d_jobs[$];
    bit          i_act = 1'b0, d_act = 1'b0, d_wr = 1'b0;
    int          i_rem = 0, d_rem = 0, i_gap = 0, d_gap = 0;
    logic [15:0] i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;

    // memory stub: read data appears LAT cycles after issue
    logic        pipe_v[LAT];
    logic [15:0] pipe_d[LAT];
    bit          spur = 1'b0;

    // reference model: phase 0 idle, 1 busy, 2 drain; owners: 0 = I, 1 = D
    int   ph = 0;
    logic own = 1'b0;
    logic last = 1'b0;
    logic oq[$];

    int   ival_cnt = 0, dval_cnt = 0;
    bit   rand_mode = 1'b0;

    task automatic client_start();
        job_t jb;
        if (!i_act) begin
            if (i_gap > 0) i_gap--;
            else if (i_jobs.size() > 0) begin
                jb = i_jobs.pop_front();
                i_act = 1'b1; i_rem = jb.n; i_addr = jb.base;
            end
        end
        if (!d_act) begin
            if (d_gap > 0) d_gap--;
            else if (d_jobs.size() > 0) begin
                jb = d_jobs.pop_front();
                d_act = 1'b1; d_rem = jb.n; d_addr = jb.base; d_wr = jb.wr; d_wdata = jb.wdata;
            end
        end
        icache_MemRead        = i_act;
        icache_mem_addr       = i_act ? i_addr : 16'($urandom);
        dcache_MemRead        = d_act & ~d_wr;
        dcache_MemWrite       = d_act & d_wr;
        dcache_mem_addr       = d_act ? d_addr : 16'($urandom);
        dcache_mem_write_data = (d_act && d_wr) ? d_wdata : 16'($urandom);
    endtask

    task automatic tick(input bit do_rst);
        logic        eg_i, eg_d, e_en, e_wr, ev_i, ev_d, o, iss;
        logic [15:0] e_addr, e_din, iss_addr;
        int          e_inf;
        rst = do_rst;
        if (do_rst) begin
            i_jobs.delete(); d_jobs.delete();
            i_act = 1'b0; d_act = 1'b0; i_gap = 0; d_gap = 0;
        end
        client_start();
        mem_data_valid = pipe_v[LAT-1] | spur;
        mem_data_out   = spur ? 16'($urandom) : pipe_d[LAT-1];
        #1;
        eg_i = 1'b0; eg_d = 1'b0;
        if (!do_rst) begin
            if (ph == 0) begin
                if ((dcache_MemRead || dcache_MemWrite) && (!icache_MemRead || last == 1'b0)) eg_d = 1'b1;
                else if (icache_MemRead) eg_i = 1'b1;
            end else if (ph == 1) begin
                if (own == 1'b0) eg_i = icache_MemRead;
                else eg_d = dcache_MemRead;
            end
        end
        e_en   = eg_i | eg_d;
        e_wr   = eg_d & ~dcache_MemRead;
        e_addr = eg_d ? dcache_mem_addr : (eg_i ? icache_mem_addr : 16'h0000);
        e_din  = eg_d ? dcache_mem_write_data : 16'h0000;
        e_inf  = do_rst ? 0 : oq.size();
        ev_i = 1'b0; ev_d = 1'b0;
        if (!do_rst && mem_data_valid && oq.size() > 0) begin
            o = oq.pop_front();
            ev_i = ~o; ev_d = o;
        end
        check_eq("grants", 32'({icache_grant, dcache_grant}), 32'({eg_i, eg_d}));
        check_eq("mem_cmd", 32'({mem_enable, mem_wr}), 32'({e_en, e_wr}));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_eq("mem_data_in", 32'(mem_data_in), 32'(e_din));
        check_eq("data_valid", 32'({icache_MemDataValid, dcache_MemDataValid}), 32'({ev_i, ev_d}));
        check_eq("read_data", 32'(arb_read_data), do_rst ? 32'h0 : 32'(mem_data_out));
        check_eq("inflight", 32'(dut.inflight_s), 32'(e_inf));
        if (icache_MemDataValid) ival_cnt++;
        if (dcache_MemDataValid) dval_cnt++;
        iss      = mem_enable & ~mem_wr;
        iss_addr = mem_addr;
        if (do_rst) begin
            ph = 0; last = 1'b0; oq.delete();
        end else begin
            if (e_en && !e_wr) oq.push_back(eg_d);
            case (ph)
                0: begin
                    if (eg_d && dcache_MemRead) begin ph = 1; own = 1'b1; end
                    else if (eg_d) last = 1'b1;
                    else if (eg_i) begin ph = 1; own = 1'b0; end
                end
                1: begin
                    if ((own == 1'b0 && !icache_MemRead) || (own == 1'b1 && !dcache_MemRead)) begin
                        last = own;
                        ph = (oq.size() == 0) ? 0 : 2;
                    end
                end
                default: if (oq.size() == 0) ph = 0;
            endcase
        end
        if (eg_i) begin
            i_rem--; i_addr = i_addr + 16'd2;
            if (i_rem == 0) begin i_act = 1'b0; i_gap = rand_mode ? $urandom_range(1, 3) : 1; end
        end
        if (eg_d) begin
            d_rem--; d_addr = d_addr + 16'd2;
            if (d_rem == 0) begin d_act = 1'b0; d_gap = rand_mode ? $urandom_range(1, 3) : 1; end
        end
        @(posedge clk);
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_d[k] = pipe_d[k-1];
        end
        pipe_v[0] = iss;
        pipe_d[0] = iss_addr ^ 16'h5A3C;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) tick(1'b0);
    endtask

    function automatic job_t mk(input int n, input logic [15:0] base, input logic wr, input logic [15:0] wd);
        job_t j;
        j.n = n; j.base = base; j.wr = wr; j.wdata = wd;
        return j;
    endfunction

    initial begin
        rst = 1'b1;
        icache_MemRead = 1'b0; dcache_MemRead = 1'b0; dcache_MemWrite = 1'b0;
        icache_mem_addr = 16'h0; dcache_mem_addr = 16'h0; dcache_mem_write_data = 16'h0;
        mem_data_out = 16'h0; mem_data_valid = 1'b0;
        for (int k = 0; k < LAT; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = 16'h0; end
        @(negedge clk);

        // reset, idle, spurious valid with nothing outstanding
        tick(1'b1); tick(1'b1);
        run(3);
        spur = 1'b1; tick(1'b0); spur = 1'b0;
        run(2);

        // 8-word I fill at 0x0040
        ival_cnt = 0; dval_cnt = 0;
        i_jobs.push_back(mk(8, 16'h0040, 1'b0, 16'h0));
        run(20);
        check_eq("ifill_valids", 32'(ival_cnt), 32'd8);
        check_eq("ifill_dvalids", 32'(dval_cnt), 32'd0);

        // simultaneous I read and D write right after reset: D wins the tie
        tick(1'b1);
        d_jobs.push_back(mk(1, 16'h1230, 1'b1, 16'hBEEF));
        i_jobs.push_back(mk(4, 16'h0100, 1'b0, 16'h0));
        run(16);

        // D write arriving mid I fill is held off until idle
        i_jobs.push_back(mk(8, 16'h0200, 1'b0, 16'h0));
        run(3);
        d_jobs.push_back(mk(1, 16'h2222, 1'b1, 16'hCAFE));
        run(24);

        // fairness: back-to-back D fills with I waiting
        d_jobs.push_back(mk(6, 16'h0300, 1'b0, 16'h0));
        d_jobs.push_back(mk(4, 16'h0340, 1'b0, 16'h0));
        run(2);
        i_jobs.push_back(mk(6, 16'h0400, 1'b0, 16'h0));
        run(40);

        // reset mid D fill with 3 reads outstanding, late valids dropped
        d_jobs.push_back(mk(8, 16'h0500, 1'b0, 16'h0));
        run(3);
        check_eq("inflight_before_rst", 32'(oq.size()), 32'd3);
        tick(1'b1);
        ival_cnt = 0; dval_cnt = 0;
        run(8);
        check_eq("late_valids_dropped", 32'(ival_cnt + dval_cnt), 32'd0);
        i_jobs.push_back(mk(8, 16'h0600, 1'b0, 16'h0));
        run(20);
        check_eq("post_rst_ifill", 32'(ival_cnt), 32'd8);

        // randomized traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!i_act && i_jobs.size() == 0 && $urandom_range(0, 5) == 0)
                i_jobs.push_back(mk($urandom_range(1, 8), 16'($urandom) & 16'hFFF0, 1'b0, 16'h0));
            if (!d_act && d_jobs.size() == 0 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 2) == 0)
                    d_jobs.push_back(mk(1, 16'($urandom), 1'b1, 16'($urandom)));
                else
                    d_jobs.push_back(mk($urandom_range(1, 8), 16'($urandom) & 16'hFFF0, 1'b0, 16'h0));
            end
            tick(1'b0);
        end
        i_jobs.delete(); d_jobs.delete();
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
